// File: rtl/bus_gate_arbiter_if.sv
// Shared-bus handshake bundle between the datapath-side driver and the gate arbiter.
// Signal names follow the LC-3 bus mux it replaces.
interface bus_gate_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
);
    localparam int SEL_W = $clog2(N_SRC);

    logic [N_SRC-1:0]       gate;
    logic [N_SRC*WIDTH-1:0] src_data;
    logic                   clr_conflict;
    logic [WIDTH-1:0]       bus_out;
    logic                   bus_valid;
    logic [SEL_W-1:0]       bus_sel;
    logic                   conflict;
    logic [CNT_W-1:0]       conflict_cnt;

    modport master (
        output gate, src_data, clr_conflict,
        input  bus_out, bus_valid, bus_sel, conflict, conflict_cnt
    );

    modport slave (
        input  gate, src_data, clr_conflict,
        output bus_out, bus_valid, bus_sel, conflict, conflict_cnt
    );
endinterface

// File: rtl/bus_gate_arbiter.sv
// Registered N-source bus mux with fixed-priority or round-robin grant,
// idle hold/park policy and a saturating multi-driver conflict counter.
module bus_gate_arbiter #(
    parameter int               WIDTH     = 16,
    parameter int               N_SRC     = 4,
    parameter int               ARB_MODE  = 0,
    parameter int               HOLD_IDLE = 1,
    parameter logic [WIDTH-1:0] IDLE_VAL  = '0,
    parameter int               CNT_W     = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    bus_gate_arbiter_if.slave  bus
);
    localparam int SEL_W = $clog2(N_SRC);

    logic [WIDTH-1:0] src_arr [N_SRC];

    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_valid_q, bus_valid_d;
    logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign src_arr[i] = bus.src_data[i*WIDTH +: WIDTH];
    end

    // Loops run from the far end down so the last hit is the winner.
    always_comb begin
        logic [SEL_W:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        if (ARB_MODE == 0) begin
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (bus.gate[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = N_SRC - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr_q} + (SEL_W + 1)'(k);
                if (idx >= (SEL_W + 1)'(N_SRC))
                    idx = idx - (SEL_W + 1)'(N_SRC);
                if (bus.gate[idx[SEL_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        bus_out_d   = bus_out_q;
        bus_valid_d = 1'b0;
        bus_sel_d   = bus_sel_q;
        rr_ptr_d    = rr_ptr_q;
        conflict_d  = ($countones(bus.gate) > 1);
        cnt_d       = cnt_q;

        if (grant_vld) begin
            bus_out_d   = src_arr[grant_idx];
            bus_valid_d = 1'b1;
            bus_sel_d   = grant_idx;
            if (ARB_MODE != 0)
                rr_ptr_d = (grant_idx == SEL_W'(N_SRC - 1)) ? '0 : grant_idx + SEL_W'(1);
        end else if (HOLD_IDLE == 0) begin
            bus_out_d = IDLE_VAL;
        end

        // A clear coinciding with a conflict leaves that conflict counted.
        if (bus.clr_conflict)
            cnt_d = conflict_d ? CNT_W'(1) : '0;
        else if (conflict_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            bus_sel_q   <= '0;
            conflict_q  <= 1'b0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
        end else begin
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            bus_sel_q   <= bus_sel_d;
            conflict_q  <= conflict_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.bus_out      = bus_out_q;
    assign bus.bus_valid    = bus_valid_q;
    assign bus.bus_sel      = bus_sel_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Drives a fixed-priority/hold instance and a round-robin/park instance with identical
// stimulus; a queue-based scoreboard compares each against a behavioural model.
module tb_bus_gate_arbiter;
    localparam int            W    = 16;
    localparam int            N    = 4;
    localparam int            CW   = 8;
    localparam logic [W-1:0]  IDLE = 16'hDEAD;

    typedef struct {
        logic [W-1:0]  bus;
        logic          valid;
        logic [1:0]    sel;
        logic          conf;
        logic [CW-1:0] cnt;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic [N-1:0]        gate_s = '0;
    logic [N-1:0][W-1:0] data_s = '0;
    logic                clr_s = 1'b0;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    int           m_ptr [2];
    logic [W-1:0] m_bus [2];
    logic [1:0]   m_sel [2];
    int           m_cnt [2];

    always #5 Clk = ~Clk;

    bus_gate_arbiter_if #(.WIDTH(W), .N_SRC(N), .CNT_W(CW)) if0 ();
    bus_gate_arbiter_if #(.WIDTH(W), .N_SRC(N), .CNT_W(CW)) if1 ();

    assign if0.gate = gate_s;
    assign if0.src_data = data_s;
    assign if0.clr_conflict = clr_s;
    assign if1.gate = gate_s;
    assign if1.src_data = data_s;
    assign if1.clr_conflict = clr_s;

    bus_gate_arbiter #(.WIDTH(W), .N_SRC(N), .ARB_MODE(0), .HOLD_IDLE(1),
                       .IDLE_VAL(16'h0), .CNT_W(CW))
        u_fixed (.Clk(Clk), .Reset(Reset), .bus(if0.slave));

    bus_gate_arbiter #(.WIDTH(W), .N_SRC(N), .ARB_MODE(1), .HOLD_IDLE(0),
                       .IDLE_VAL(IDLE), .CNT_W(CW))
        u_rr (.Clk(Clk), .Reset(Reset), .bus(if1.slave));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endfunction

    // Reference: grant is the first requesting source walking upward from the
    // search base (0 for fixed priority, the rotating pointer for round-robin).
    function automatic exp_t model(int m, logic rst, logic [N-1:0] g, logic clr,
                                   logic [N-1:0][W-1:0] d);
        exp_t e;
        int   n, win, base;
        if (!rst) begin
            m_ptr[m] = 0; m_bus[m] = '0; m_sel[m] = '0; m_cnt[m] = 0;
            e.bus = '0; e.valid = 1'b0; e.sel = '0; e.conf = 1'b0; e.cnt = '0;
            return e;
        end
        n = 0;
        for (int i = 0; i < N; i++) n += int'(g[i]);
        base = (m == 0) ? 0 : m_ptr[m];
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && g[(base + k) % N]) win = (base + k) % N;
        end
        if (win >= 0) begin
            m_bus[m] = d[win];
            m_sel[m] = 2'(win);
            if (m == 1) m_ptr[m] = (win + 1) % N;
        end else if (m == 1) begin
            m_bus[m] = IDLE;
        end
        if (clr) m_cnt[m] = (n > 1) ? 1 : 0;
        else if (n > 1 && m_cnt[m] < 255) m_cnt[m] = m_cnt[m] + 1;
        e.bus = m_bus[m]; e.valid = (win >= 0); e.sel = m_sel[m];
        e.conf = (n > 1); e.cnt = CW'(m_cnt[m]);
        return e;
    endfunction

    task automatic drive(input logic rst, input logic [N-1:0] g, input logic clr, input int d2);
        @(negedge Clk);
        Reset = rst; gate_s = g; clr_s = clr;
        for (int i = 0; i < N; i++) data_s[i] = W'($urandom);
        if (d2 >= 0) data_s[2] = W'(d2);
        q0.push_back(model(0, rst, g, clr, data_s));
        q1.push_back(model(1, rst, g, clr, data_s));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("fixed.bus_out",   32'(if0.bus_out),      32'(e.bus));
                chk("fixed.bus_valid", 32'(if0.bus_valid),    32'(e.valid));
                chk("fixed.bus_sel",   32'(if0.bus_sel),      32'(e.sel));
                chk("fixed.conflict",  32'(if0.conflict),     32'(e.conf));
                chk("fixed.cnt",       32'(if0.conflict_cnt), 32'(e.cnt));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("rr.bus_out",   32'(if1.bus_out),      32'(e.bus));
                chk("rr.bus_valid", 32'(if1.bus_valid),    32'(e.valid));
                chk("rr.bus_sel",   32'(if1.bus_sel),      32'(e.sel));
                chk("rr.conflict",  32'(if1.conflict),     32'(e.conf));
                chk("rr.cnt",       32'(if1.conflict_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        // Reset with every gate raised
        drive(1'b0, 4'hF, 1'b0, -1);
        drive(1'b0, 4'hF, 1'b0, -1);
        // Single gate, then idle hold / park
        drive(1'b1, 4'b0100, 1'b0, 16'h3000);
        drive(1'b1, 4'b0000, 1'b0, -1);
        drive(1'b1, 4'b0000, 1'b0, -1);
        // Two drivers, long enough to saturate the counter
        for (int i = 0; i < 300; i++) drive(1'b1, 4'b1010, 1'b0, -1);
        drive(1'b1, 4'b0011, 1'b1, -1);
        drive(1'b1, 4'b0001, 1'b1, -1);
        // Round-robin rotation with wrap from a fresh pointer
        drive(1'b0, 4'h0, 1'b0, -1);
        for (int i = 0; i < 6; i++) drive(1'b1, 4'hF, 1'b0, -1);
        // Reset mid-burst must rewind the pointer
        drive(1'b0, 4'h0, 1'b0, -1);
        drive(1'b1, 4'b0100, 1'b0, -1);
        drive(1'b0, 4'b0100, 1'b0, -1);
        drive(1'b1, 4'b1001, 1'b0, -1);
        // Random traffic
        for (int i = 0; i < 1500; i++)
            drive(($urandom_range(0, 99) != 0), N'($urandom), ($urandom_range(0, 19) == 0), -1);
        drive(1'b1, 4'h0, 1'b0, -1);
        repeat (3) @(negedge Clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d/%0d pending expected=0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
